// File: rtl/combo_lock_ctrl_pkg.sv
// Shared definitions for the combination lock controller: FSM state
// encoding, display constants and a small saturating-counter helper.
package combo_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5,
    ST_PROG    = 3'd6
  } state_t;

  localparam logic [3:0] DISP_IDLE = 4'h0;
  localparam logic [3:0] DISP_OPEN = 4'hA;
  localparam logic [3:0] DISP_LOCK = 4'hE;

  // Three-bit increment that sticks at 7 instead of wrapping.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/combo_lock_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stable-level debouncer. Emits a single-cycle
// pulse once the input has been high for CYCLES consecutive cycles, and
// re-arms only after CYCLES consecutive low cycles.
module btn_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;
  logic             r_pulse;
  logic             w_level;

  assign w_level = r_sync[1];
  assign o_pulse = r_pulse;

  // Bring the raw input into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_btn};
  end

  // Count stable cycles in the current level; flip pressed state and pulse on press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_level != r_pressed) begin
        if (r_cnt == LAST) begin
          r_cnt     <= '0;
          r_pressed <= w_level;
          r_pulse   <= w_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: collects debounced keypad digits, checks them
// against the stored user code or the fixed override code, handles relock,
// lockout after repeated failures, and user-code re-programming.
module combo_lock_ctrl
  import combo_lock_ctrl_pkg::*;
#(
  parameter int                      CODE_LEN        = 4,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE    = 16'h1234,
  parameter logic [4*CODE_LEN-1:0]   OVERRIDE_CODE   = 16'h9999,
  parameter int                      MAX_FAIL        = 3,
  parameter int                      DEBOUNCE_CYCLES = 1_000_000,
  parameter int                      UNLOCK_CYCLES   = 500_000_000,
  parameter int                      LOCKOUT_CYCLES  = 1_000_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_key_val,
  input  logic       i_key_ping,
  input  logic       i_btn_enter,
  input  logic       i_btn_prog,
  output logic       o_unlocked,
  output logic       o_alarm,
  output logic       o_prog_mode,
  output logic [2:0] o_fail_cnt,
  output logic [3:0] o_entry_cnt,
  output logic [3:0] o_disp_val
);

  localparam int EW = 4 * CODE_LEN;
  localparam logic [3:0]  CNT_MAX     = 4'(CODE_LEN);
  localparam logic [2:0]  FAIL_LIMIT  = 3'(MAX_FAIL);
  localparam logic [31:0] UNLOCK_LAST = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST   = 32'(LOCKOUT_CYCLES - 1);

  state_t        r_state, w_state_next;
  logic [EW-1:0] r_entry, w_entry_next;
  logic [EW-1:0] r_code, w_code_next;
  logic [3:0]    r_entry_cnt, w_cnt_next;
  logic [3:0]    r_digit, w_digit_next;
  logic [2:0]    r_fail_cnt, w_fail_next;
  logic [31:0]   r_timer, w_timer_next;
  logic          r_enter_pend;

  logic w_key_p, w_enter_p, w_prog_p;
  logic w_enter_raw, w_enter, w_capture, w_match;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_key (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_key_ping), .o_pulse(w_key_p));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_enter), .o_pulse(w_enter_p));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_prog), .o_pulse(w_prog_p));

  // A key always wins its cycle; an enter that collides with it is replayed next cycle.
  assign w_enter_raw = w_enter_p | r_enter_pend;
  assign w_enter     = w_enter_raw & ~w_key_p;
  assign w_match     = (r_entry_cnt == CNT_MAX) &&
                       ((r_entry == r_code) || (r_entry == OVERRIDE_CODE));

  assign o_fail_cnt  = r_fail_cnt;
  assign o_entry_cnt = r_entry_cnt;

  // State and datapath registers; reset restores the default user code.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_entry      <= '0;
      r_code       <= DEFAULT_CODE;
      r_entry_cnt  <= '0;
      r_digit      <= '0;
      r_fail_cnt   <= '0;
      r_timer      <= '0;
      r_enter_pend <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_entry      <= w_entry_next;
      r_code       <= w_code_next;
      r_entry_cnt  <= w_cnt_next;
      r_digit      <= w_digit_next;
      r_fail_cnt   <= w_fail_next;
      r_timer      <= w_timer_next;
      r_enter_pend <= w_enter_raw & w_key_p;
    end
  end

  // Next-state and datapath updates for the lock sequencer.
  always_comb begin
    w_state_next = r_state;
    w_entry_next = r_entry;
    w_code_next  = r_code;
    w_cnt_next   = r_entry_cnt;
    w_digit_next = r_digit;
    w_fail_next  = r_fail_cnt;
    w_timer_next = r_timer;
    w_capture    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_key_p) begin
          w_capture    = 1'b1;
          w_state_next = ST_ENTRY;
        end else if (w_enter) begin
          w_state_next = ST_FAIL;
        end
      end
      ST_ENTRY: begin
        if (w_key_p)      w_capture    = 1'b1;
        else if (w_enter) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        w_entry_next = '0;
        w_cnt_next   = '0;
        w_timer_next = '0;
        if (w_match) begin
          w_state_next = ST_OPEN;
          w_fail_next  = '0;
        end else begin
          w_state_next = ST_FAIL;
        end
      end
      ST_FAIL: begin
        w_fail_next  = sat_inc3(r_fail_cnt);
        w_timer_next = '0;
        w_state_next = (sat_inc3(r_fail_cnt) >= FAIL_LIMIT) ? ST_LOCKOUT : ST_IDLE;
      end
      ST_OPEN: begin
        if (w_enter) begin
          w_state_next = ST_IDLE;
          w_timer_next = '0;
        end else if (w_prog_p) begin
          w_state_next = ST_PROG;
          w_entry_next = '0;
          w_cnt_next   = '0;
        end else if (r_timer == UNLOCK_LAST) begin
          w_state_next = ST_IDLE;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      ST_PROG: begin
        if (w_key_p) begin
          w_capture = 1'b1;
        end else if (w_enter) begin
          if ((r_entry_cnt == CNT_MAX) && (r_entry != OVERRIDE_CODE))
            w_code_next = r_entry;
          w_state_next = ST_IDLE;
          w_entry_next = '0;
          w_cnt_next   = '0;
          w_timer_next = '0;
        end else if (w_prog_p) begin
          w_state_next = ST_OPEN;
          w_entry_next = '0;
          w_cnt_next   = '0;
          w_timer_next = '0;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == LOCK_LAST) begin
          w_state_next = ST_IDLE;
          w_fail_next  = '0;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_capture && (r_entry_cnt < CNT_MAX)) begin
      w_entry_next = {r_entry[EW-5:0], i_key_val};
      w_cnt_next   = r_entry_cnt + 4'd1;
      w_digit_next = i_key_val;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_unlocked  = (r_state == ST_OPEN) || (r_state == ST_PROG);
    o_alarm     = (r_state == ST_LOCKOUT);
    o_prog_mode = (r_state == ST_PROG);
    case (r_state)
      ST_ENTRY, ST_PROG: o_disp_val = r_digit;
      ST_OPEN:           o_disp_val = DISP_OPEN;
      ST_LOCKOUT:        o_disp_val = DISP_LOCK;
      default:           o_disp_val = DISP_IDLE;
    endcase
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed self-checking bench for combo_lock_ctrl with short debounce,
// relock and lockout times so every path is reachable in a few thousand cycles.
module tb_combo_lock_ctrl;
  import combo_lock_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] keyVal;
  logic       keyPing, btnEnter, btnProg;
  logic       unlocked, alarm, progMode;
  logic [2:0] failCnt;
  logic [3:0] entryCnt, dispVal;

  int passCount  = 0;
  int totalCount = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .OVERRIDE_CODE(16'h9999),
    .MAX_FAIL(3), .DEBOUNCE_CYCLES(4), .UNLOCK_CYCLES(50), .LOCKOUT_CYCLES(100)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_key_val(keyVal), .i_key_ping(keyPing),
    .i_btn_enter(btnEnter), .i_btn_prog(btnProg), .o_unlocked(unlocked),
    .o_alarm(alarm), .o_prog_mode(progMode), .o_fail_cnt(failCnt),
    .o_entry_cnt(entryCnt), .o_disp_val(dispVal)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind 0 = key press with value, 1 = enter, 2 = program button.
  task automatic applyStimulus(input int kind, input logic [3:0] val);
    keyVal = val;
    case (kind)
      0:       keyPing  = 1'b1;
      1:       btnEnter = 1'b1;
      default: btnProg  = 1'b1;
    endcase
    waitCycles(8);
    keyPing = 1'b0; btnEnter = 1'b0; btnProg = 1'b0;
    waitCycles(8);
  endtask

  task automatic enterCode(input logic [15:0] code);
    for (int i = 0; i < 4; i++) applyStimulus(0, code[15-4*i -: 4]);
    applyStimulus(1, 4'h0);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    waitCycles(3);
    rstN = 1'b1;
    waitCycles(2);
  endtask

  // Safety net against a hung DUT handshake.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  cnt;
    int  i;
    logic seen;
    rstN = 1'b0; keyVal = 4'h0; keyPing = 1'b0; btnEnter = 1'b0; btnProg = 1'b0;
    waitCycles(3);
    checkOutput("rst_unlocked", 32'(unlocked), 32'd0);
    checkOutput("rst_alarm",    32'(alarm),    32'd0);
    checkOutput("rst_prog",     32'(progMode), 32'd0);
    checkOutput("rst_fail",     32'(failCnt),  32'd0);
    checkOutput("rst_entry",    32'(entryCnt), 32'd0);
    checkOutput("rst_disp",     32'(dispVal),  32'd0);
    checkOutput("rst_state",    32'(dut.r_state), 32'(ST_IDLE));
    rstN = 1'b1;
    waitCycles(2);

    $display("[TB] test 1: default code unlock and auto-relock");
    applyStimulus(0, 4'h1);
    checkOutput("t1_cnt1", 32'(entryCnt), 32'd1);
    checkOutput("t1_state_entry", 32'(dut.r_state), 32'(ST_ENTRY));
    applyStimulus(0, 4'h2);
    applyStimulus(0, 4'h3);
    applyStimulus(0, 4'h4);
    checkOutput("t1_cnt4", 32'(entryCnt), 32'd4);
    checkOutput("t1_disp4", 32'(dispVal), 32'h4);
    btnEnter = 1'b1;
    seen = 1'b0;
    for (i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (dut.r_state == ST_CHECK) seen = 1'b1;
    end
    checkOutput("t1_check_seen", 32'(seen), 32'd1);
    checkOutput("t1_check_locked", 32'(unlocked), 32'd0);
    @(negedge clk);
    checkOutput("t1_open_unlocked", 32'(unlocked), 32'd1);
    checkOutput("t1_open_disp", 32'(dispVal), 32'hA);
    cnt = 1;
    i = 0;
    while (unlocked && i < 200) begin
      @(negedge clk);
      i++;
      if (unlocked) cnt++;
    end
    checkOutput("t1_open_cycles", 32'(cnt), 32'd50);
    checkOutput("t1_relock_state", 32'(dut.r_state), 32'(ST_IDLE));
    btnEnter = 1'b0;
    waitCycles(8);

    $display("[TB] test 2: three failures lead to lockout");
    enterCode(16'h5555);
    checkOutput("t2_fail1", 32'(failCnt), 32'd1);
    checkOutput("t2_idle1", 32'(dut.r_state), 32'(ST_IDLE));
    enterCode(16'h5555);
    checkOutput("t2_fail2", 32'(failCnt), 32'd2);
    for (int k = 0; k < 4; k++) applyStimulus(0, 4'h5);
    btnEnter = 1'b1;
    seen = 1'b0;
    for (i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (alarm) seen = 1'b1;
    end
    checkOutput("t2_alarm_seen", 32'(seen), 32'd1);
    checkOutput("t2_fail3", 32'(failCnt), 32'd3);
    checkOutput("t2_disp_lock", 32'(dispVal), 32'hE);
    btnEnter = 1'b0;
    cnt = 1;
    i = 0;
    keyVal = 4'h1;
    while (alarm && i < 400) begin
      @(negedge clk);
      i++;
      if (i == 10) keyPing = 1'b1;
      if (i == 20) keyPing = 1'b0;
      if (alarm) cnt++;
    end
    checkOutput("t2_lock_cycles", 32'(cnt), 32'd100);
    checkOutput("t2_key_ignored", 32'(entryCnt), 32'd0);
    checkOutput("t2_fail_clear", 32'(failCnt), 32'd0);
    checkOutput("t2_idle_after", 32'(dut.r_state), 32'(ST_IDLE));
    waitCycles(8);

    $display("[TB] test 3: override code after two failures");
    enterCode(16'h5555);
    enterCode(16'h5555);
    checkOutput("t3_fail2", 32'(failCnt), 32'd2);
    enterCode(16'h9999);
    checkOutput("t3_unlocked", 32'(unlocked), 32'd1);
    checkOutput("t3_fail0", 32'(failCnt), 32'd0);
    applyStimulus(1, 4'h0);
    checkOutput("t3_enter_relock", 32'(unlocked), 32'd0);

    $display("[TB] test 4: reprogram user code");
    enterCode(16'h1234);
    checkOutput("t4_open", 32'(unlocked), 32'd1);
    applyStimulus(2, 4'h0);
    checkOutput("t4_prog_mode", 32'(progMode), 32'd1);
    checkOutput("t4_prog_unlocked", 32'(unlocked), 32'd1);
    applyStimulus(0, 4'h7);
    applyStimulus(0, 4'h7);
    applyStimulus(0, 4'h0);
    applyStimulus(0, 4'h1);
    checkOutput("t4_prog_cnt", 32'(entryCnt), 32'd4);
    checkOutput("t4_prog_disp", 32'(dispVal), 32'h1);
    applyStimulus(1, 4'h0);
    checkOutput("t4_prog_exit", 32'(progMode), 32'd0);
    checkOutput("t4_prog_locked", 32'(unlocked), 32'd0);
    enterCode(16'h1234);
    checkOutput("t4_old_fails", 32'(failCnt), 32'd1);
    checkOutput("t4_old_locked", 32'(unlocked), 32'd0);
    enterCode(16'h7701);
    checkOutput("t4_new_opens", 32'(unlocked), 32'd1);
    checkOutput("t4_new_fail0", 32'(failCnt), 32'd0);
    applyStimulus(1, 4'h0);
    doReset();
    enterCode(16'h1234);
    checkOutput("t4_default_back", 32'(unlocked), 32'd1);
    applyStimulus(1, 4'h0);

    $display("[TB] test 5: glitch rejection and entry saturation");
    keyVal = 4'h8;
    keyPing = 1'b1;
    waitCycles(2);
    keyPing = 1'b0;
    waitCycles(8);
    checkOutput("t5_glitch", 32'(entryCnt), 32'd0);
    keyVal = 4'h1;
    keyPing = 1'b1;
    waitCycles(10);
    keyPing = 1'b0;
    waitCycles(8);
    checkOutput("t5_one_digit", 32'(entryCnt), 32'd1);
    checkOutput("t5_digit_val", 32'(dispVal), 32'h1);
    applyStimulus(0, 4'h2);
    applyStimulus(0, 4'h3);
    applyStimulus(0, 4'h4);
    applyStimulus(0, 4'h9);
    checkOutput("t5_saturate", 32'(entryCnt), 32'd4);
    checkOutput("t5_disp_last", 32'(dispVal), 32'h4);
    applyStimulus(1, 4'h0);
    checkOutput("t5_first_four", 32'(unlocked), 32'd1);
    applyStimulus(1, 4'h0);

    $display("[TB] test 7: simultaneous key and enter");
    applyStimulus(0, 4'h1);
    applyStimulus(0, 4'h2);
    applyStimulus(0, 4'h3);
    keyVal = 4'h4;
    keyPing = 1'b1;
    btnEnter = 1'b1;
    waitCycles(8);
    keyPing = 1'b0;
    btnEnter = 1'b0;
    waitCycles(8);
    checkOutput("t7_key_then_enter", 32'(unlocked), 32'd1);
    applyStimulus(1, 4'h0);

    $display("[TB] test 6: asynchronous reset mid-entry and in OPEN");
    applyStimulus(0, 4'h1);
    applyStimulus(0, 4'h2);
    checkOutput("t6_pre_cnt", 32'(entryCnt), 32'd2);
    #1 rstN = 1'b0;
    #1;
    checkOutput("t6_async_cnt", 32'(entryCnt), 32'd0);
    checkOutput("t6_async_disp", 32'(dispVal), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    waitCycles(2);
    checkOutput("t6_idle1", 32'(dut.r_state), 32'(ST_IDLE));
    enterCode(16'h1234);
    checkOutput("t6_open", 32'(unlocked), 32'd1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("t6_async_unlock", 32'(unlocked), 32'd0);
    checkOutput("t6_async_disp2", 32'(dispVal), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    waitCycles(2);
    checkOutput("t6_idle2", 32'(dut.r_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
- Sequencing controller for the combination lock.
- Consumes decoded keypad nibbles and the key-activity ping from the keypad decoder, plus the centre pushbutton as Enter and a program button.
- Assembles a multi-digit entry, compares it against the stored user code and a fixed override code, and drives lock, alarm and lockout status.
- Supplies the nibble shown on the seven-segment display controller. Supports re-programming the user code while unlocked.

Parameters:
- CODE_LEN, 4, digits per code (2..8).
- DEFAULT_CODE, 16'h1234, user code after reset, CODE_LEN nibbles, MS nibble entered first.
- OVERRIDE_CODE, 16'h9999, master code; never overwritten.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7).
- DEBOUNCE_CYCLES, 1_000_000, stable cycles required on key_ping and the buttons.
- UNLOCK_CYCLES, 500_000_000, auto-relock time in OPEN.
- LOCKOUT_CYCLES, 1_000_000_000, lockout duration.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- key_val  in  4  decoded key nibble from the keypad decoder.
- key_ping  in  1  high while a key is held (decoder ping).
- btn_enter  in  1  raw Enter pushbutton (btnC).
- btn_prog  in  1  raw program-mode pushbutton.
- unlocked  out  1  lock released.
- alarm  out  1  high during LOCKOUT.
- prog_mode  out  1  high in PROG.
- fail_cnt  out  3  consecutive failures.
- entry_cnt  out  4  digits captured in the current entry.
- disp_val  out  4  nibble for the seven-segment display.

Behaviour:
- Reset values: all outputs 0; state IDLE; stored code = DEFAULT_CODE; code_set = 0; timers and counters cleared.
- Input conditioning:
  - key_ping, btn_enter and btn_prog each pass through a 2-flop synchroniser.
  - Each is then debounced: a press is recognised once the input has been high for DEBOUNCE_CYCLES consecutive cycles, producing a 1-cycle pulse.
  - A debouncer re-arms only after DEBOUNCE_CYCLES consecutive low cycles.
  - key_val is sampled in the cycle the key pulse fires.
- Entry register: CODE_LEN nibbles, shifted left, new digit into the LS nibble; entry_cnt saturates at CODE_LEN and further digits are ignored. All 16 key values are valid digits.
- Simultaneous key and enter pulses in the same cycle: the key is processed first, then enter in the following cycle (enter is held pending for one cycle).
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT, PROG.
- IDLE:
  - key pulse: capture digit, go to ENTRY.
  - enter pulse: counts as a failed attempt, go to FAIL.
  - prog pulse: ignored.
- ENTRY:
  - key pulse: capture digit.
  - enter pulse: go to CHECK.
- CHECK (exactly 1 cycle):
  - Match requires entry_cnt == CODE_LEN and entry equal to the stored code or OVERRIDE_CODE.
  - Match: go to OPEN, fail_cnt = 0.
  - Otherwise: go to FAIL.
  - Entry register cleared either way.
  - unlocked rises on the cycle after CHECK.
- FAIL (1 cycle): fail_cnt increments, saturating at 7. If the new value is ≥ MAX_FAIL, go to LOCKOUT; else go to IDLE.
- OPEN:
  - unlocked = 1; relock timer counts.
  - Timer reaching UNLOCK_CYCLES-1: go to IDLE.
  - enter pulse: relock immediately, go to IDLE.
  - prog pulse: go to PROG; the timer is stopped.
- PROG:
  - prog_mode = 1; unlocked = 1.
  - key pulse: capture digit.
  - enter pulse with entry_cnt == CODE_LEN: stored code = entry, code_set = 1, go to IDLE (locked).
  - enter pulse with a short entry: abort, code unchanged, go to IDLE.
  - prog pulse: abort, go to OPEN with the relock timer restarted.
  - An entry equal to OVERRIDE_CODE is rejected (treated as abort).
- LOCKOUT:
  - alarm = 1; all key and button pulses are discarded.
  - After LOCKOUT_CYCLES: fail_cnt = 0, go to IDLE.
- disp_val:
  - Last captured digit in ENTRY and PROG.
  - 4'hA in OPEN; 4'hE in LOCKOUT; 4'h0 in IDLE.
- Reset mid-operation: everything returns to reset values, including the stored code (reverts to DEFAULT_CODE).

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE..PROG, 3 bits);
  - display constants DISP_OPEN = 4'hA, DISP_LOCK = 4'hE.
- One sub-module is natural: btn_debounce (2-flop synchroniser, stable counter, 1-cycle rising pulse, clk/reset active-low, parameter CYCLES). It is instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, UNLOCK_CYCLES=50, LOCKOUT_CYCLES=100, CODE_LEN=4):
1. Enter keys 1,2,3,4 then enter → CHECK for one cycle, unlocked=1 on the following cycle, disp_val=A; after 50 cycles unlocked=0 and state is IDLE.
2. Three wrong codes (5,5,5,5 + enter) → fail_cnt goes 1, 2, 3; alarm=1 and disp_val=E; keys during lockout are ignored; after 100 cycles alarm=0 and fail_cnt=0.
3. Override 9,9,9,9 entered after two failures → unlocked=1, fail_cnt=0.
4. Unlock, prog pulse, keys 7,7,0,1, enter → prog_mode pulses high then low; code 1234 now fails and 7701 unlocks; after reset, 1234 unlocks again.
5. Key_ping glitch of 2 cycles → no digit captured; held 10 cycles → exactly one digit captured; five digits then enter → entry_cnt stays 4 and the first four digits are compared.
6. Reset asserted in the middle of entry and in OPEN → all outputs 0 asynchronously, state IDLE on release.
